// File: rtl/counter_shift_sequencer_pkg.sv
// Shared types and encodings for the counter/shift-register schedule sequencer.
package cs_seq_pkg;

  // Schedule states; the encoding doubles as the debug phase code.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLR    = 4'd1,
    S_UP_BIN = 4'd2,
    S_DN_BIN = 4'd3,
    S_UP_BCD = 4'd4,
    S_DN_BCD = 4'd5,
    S_SH_PAR = 4'd6,
    S_SH_R   = 4'd7,
    S_SH_L   = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  localparam logic [1:0] SH_PARALLEL = 2'b00;
  localparam logic [1:0] SH_RIGHT    = 2'b01;
  localparam logic [1:0] SH_LEFT     = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic CODE_BIN = 1'b0;
  localparam logic CODE_BCD = 1'b1;

  // Control word driven to the counter / shift-register datapath.
  typedef struct packed {
    logic       en;
    logic       sel1;
    logic       sel2;
    logic [1:0] sel3;
    logic       ctr_rstn;
    logic       busy;
    logic       done;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{en: 1'b1, sel1: DIR_UP, sel2: CODE_BIN, sel3: SH_PARALLEL,
                                ctr_rstn: 1'b0, busy: 1'b0, done: 1'b0};

endpackage

// File: rtl/counter_shift_sequencer_if.sv
// Handshake and datapath-control bundle between a controller and the sequencer.
interface counter_shift_sequencer_if;
  logic       start;
  logic       abort;
  logic [3:0] preset_in;
  logic       En;
  logic       SEL1;
  logic       SEL2;
  logic [1:0] SEL3;
  logic [3:0] preset;
  logic       ctr_rstn;
  logic       busy;
  logic       done;
  logic [3:0] phase;

  modport master (output start, abort, preset_in,
                  input  En, SEL1, SEL2, SEL3, preset, ctr_rstn, busy, done, phase);
  modport slave  (input  start, abort, preset_in,
                  output En, SEL1, SEL2, SEL3, preset, ctr_rstn, busy, done, phase);
endinterface

// File: rtl/counter_shift_sequencer_dwell_timer.sv
// Loadable down-counter with a registered zero flag, used to time each phase.
module dwell_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load takes priority; otherwise count down and saturate at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      cnt_q <= load_val;
      zero  <= (load_val == '0);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
      zero  <= (cnt_q == W'(1));
    end
  end

endmodule

// File: rtl/counter_shift_sequencer.sv
// Sequences the counter / shift-register datapath through its mode schedule.
// Optional feature: SEQ_BCD_MODES_EN adds the UP_BCD and DN_BCD counter phases.
module counter_shift_sequencer
  import cs_seq_pkg::*;
#(
  parameter int unsigned CNT_DWELL   = 40,
  parameter int unsigned SHIFT_DWELL = 4
) (
  input logic                     clk,
  input logic                     rst,
  counter_shift_sequencer_if.slave bus
);

  localparam int unsigned MAX_DWELL  = (CNT_DWELL > SHIFT_DWELL) ? CNT_DWELL : SHIFT_DWELL;
  localparam int unsigned TW         = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
  localparam logic [TW-1:0] CNT_LOAD = TW'(CNT_DWELL - 1);
  localparam logic [TW-1:0] SH_LOAD  = TW'(SHIFT_DWELL - 1);
`ifdef SEQ_BCD_MODES_EN
  localparam logic SH_CODE = CODE_BCD;
`else
  localparam logic SH_CODE = CODE_BIN;
`endif

  state_t        state_q, state_d;
  ctl_t          ctl_q, ctl_d;
  logic [3:0]    preset_q;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  dwell_timer #(.W(TW)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State, registered control word and latched preset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ctl_q    <= CTL_IDLE;
      preset_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      if (state_q == S_IDLE && state_d == S_CLR) preset_q <= bus.preset_in;
    end
  end

  // Next state: walk the schedule, advancing when the dwell timer expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start && !bus.abort) state_d = S_CLR;
      S_CLR:    state_d = S_UP_BIN;
      S_UP_BIN: if (tmr_zero) state_d = S_DN_BIN;
      S_DN_BIN: if (tmr_zero) begin
`ifdef SEQ_BCD_MODES_EN
        state_d = S_UP_BCD;
`else
        state_d = S_SH_PAR;
`endif
      end
`ifdef SEQ_BCD_MODES_EN
      S_UP_BCD: if (tmr_zero) state_d = S_DN_BCD;
      S_DN_BCD: if (tmr_zero) state_d = S_SH_PAR;
`endif
      S_SH_PAR: if (tmr_zero) state_d = S_SH_R;
      S_SH_R:   if (tmr_zero) state_d = S_SH_L;
      S_SH_L:   if (tmr_zero) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && bus.abort) state_d = S_IDLE;
  end

  // Control word and dwell reload decoded from the upcoming state so outputs stay registered.
  always_comb begin
    ctl_d    = CTL_IDLE;
    tmr_val  = '0;
    tmr_load = (state_d != state_q);
    case (state_d)
      S_CLR: ctl_d.busy = 1'b1;
      S_UP_BIN, S_DN_BIN
`ifdef SEQ_BCD_MODES_EN
      , S_UP_BCD, S_DN_BCD
`endif
      : begin
        ctl_d.busy     = 1'b1;
        ctl_d.ctr_rstn = 1'b1;
        ctl_d.sel1     = (state_d == S_UP_BIN || state_d == S_UP_BCD) ? DIR_UP : DIR_DOWN;
        ctl_d.sel2     = (state_d == S_UP_BCD || state_d == S_DN_BCD) ? CODE_BCD : CODE_BIN;
        tmr_val        = CNT_LOAD;
      end
      S_SH_PAR, S_SH_R, S_SH_L: begin
        ctl_d.busy     = 1'b1;
        ctl_d.ctr_rstn = 1'b1;
        ctl_d.en       = 1'b0;
        ctl_d.sel1     = DIR_DOWN;
        ctl_d.sel2     = SH_CODE;
        ctl_d.sel3     = (state_d == S_SH_PAR) ? SH_PARALLEL :
                         (state_d == S_SH_R)   ? SH_RIGHT : SH_LEFT;
        tmr_val        = SH_LOAD;
      end
      S_DONE: begin
        ctl_d.busy = 1'b1;
        ctl_d.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.En       = ctl_q.en;
  assign bus.SEL1     = ctl_q.sel1;
  assign bus.SEL2     = ctl_q.sel2;
  assign bus.SEL3     = ctl_q.sel3;
  assign bus.ctr_rstn = ctl_q.ctr_rstn;
  assign bus.busy     = ctl_q.busy;
  assign bus.done     = ctl_q.done;
  assign bus.preset   = preset_q;
  assign bus.phase    = 4'(state_q);

endmodule

// File: tb/tb_counter_shift_sequencer.sv
// Scoreboard bench for counter_shift_sequencer with CNT_DWELL=4, SHIFT_DWELL=2.
module tb_counter_shift_sequencer;

  localparam int TB_C = 4;
  localparam int TB_S = 2;
`ifdef SEQ_BCD_MODES_EN
  localparam int NS = 9;
  localparam int LAT = 23;
  localparam int ABORT_PH = 4;
  localparam int SH_SEL2 = 1;
  int sched [NS] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
`else
  localparam int NS = 7;
  localparam int LAT = 15;
  localparam int ABORT_PH = 3;
  localparam int SH_SEL2 = 0;
  int sched [NS] = '{1, 2, 3, 6, 7, 8, 9};
`endif
  // DONE cycle, one IDLE cycle, then a complete run up to the next DONE.
  localparam int DONE_GAP = LAT + 2;

  typedef struct {
    int phase, at, en, sel1, sel2, sel3, rstn, busy, done, preset;
    bit chk_sel, chk_rstn;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_phase = 0;
  exp_t exp_q[$];
  int   done_cyc[$];
  int   e0, t_last;

  counter_shift_sequencer_if bus ();

  counter_shift_sequencer #(.CNT_DWELL(TB_C), .SHIFT_DWELL(TB_S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int dwell_of(input int ph);
    if (ph >= 2 && ph <= 5) return TB_C;
    if (ph >= 6 && ph <= 8) return TB_S;
    return 1;
  endfunction

  function automatic exp_t make_exp(input int ph, input int at, input int p);
    exp_t e;
    e = '{phase: ph, at: at, en: 1, sel1: 1, sel2: 0, sel3: 0, rstn: 0, busy: 1, done: 0,
          preset: p, chk_sel: 1'b1, chk_rstn: 1'b1};
    case (ph)
      0: e.busy = 0;
      1: e.chk_sel = 1'b0;
      2: e.rstn = 1;
      3: begin e.rstn = 1; e.sel1 = 0; end
      4: begin e.rstn = 1; e.sel2 = 1; end
      5: begin e.rstn = 1; e.sel1 = 0; e.sel2 = 1; end
      6, 7, 8: begin
        e.en = 0; e.sel1 = 0; e.sel2 = SH_SEL2; e.sel3 = ph - 6; e.chk_rstn = 1'b0;
      end
      default: begin e.done = 1; e.chk_sel = 1'b0; e.chk_rstn = 1'b0; end
    endcase
    return e;
  endfunction

  // Queue the expected phase entries of one run starting at edge e0_in, up to phase upto.
  task automatic push_sched(input int p, input int e0_in, input int upto, output int tl);
    int t;
    t  = e0_in;
    tl = e0_in;
    for (int i = 0; i < NS; i++) begin
      exp_q.push_back(make_exp(sched[i], t, p));
      tl = t;
      if (sched[i] == upto) break;
      t += dwell_of(sched[i]);
    end
    if (upto == 9) exp_q.push_back(make_exp(0, tl + 1, p));
  endtask

  // Monitor: every phase change pops one expected entry and compares it.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_phase = 0;
    end else begin
      if (int'(bus.phase) != last_phase) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_phase", int'(bus.phase), last_phase);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("ph%0d_phase", e.phase), int'(bus.phase), e.phase);
          chk($sformatf("ph%0d_cycle", e.phase), cyc, e.at);
          chk($sformatf("ph%0d_busy", e.phase), int'(bus.busy), e.busy);
          chk($sformatf("ph%0d_done", e.phase), int'(bus.done), e.done);
          chk($sformatf("ph%0d_preset", e.phase), int'(bus.preset), e.preset);
          if (e.chk_sel) begin
            chk($sformatf("ph%0d_En", e.phase), int'(bus.En), e.en);
            chk($sformatf("ph%0d_SEL1", e.phase), int'(bus.SEL1), e.sel1);
            chk($sformatf("ph%0d_SEL2", e.phase), int'(bus.SEL2), e.sel2);
            chk($sformatf("ph%0d_SEL3", e.phase), int'(bus.SEL3), e.sel3);
          end
          if (e.chk_rstn) chk($sformatf("ph%0d_ctr_rstn", e.phase), int'(bus.ctr_rstn), e.rstn);
          if (e.phase == 9) done_cyc.push_back(cyc);
        end
        last_phase = int'(bus.phase);
      end
`ifndef SEQ_BCD_MODES_EN
      chk("sel2_tied_low", int'(bus.SEL2), 0);
`endif
    end
  end

  task automatic nedge();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset(input string name);
    chk({name, "_En"}, int'(bus.En), 1);
    chk({name, "_SEL1"}, int'(bus.SEL1), 1);
    chk({name, "_SEL2"}, int'(bus.SEL2), 0);
    chk({name, "_SEL3"}, int'(bus.SEL3), 0);
    chk({name, "_ctr_rstn"}, int'(bus.ctr_rstn), 0);
    chk({name, "_busy"}, int'(bus.busy), 0);
    chk({name, "_done"}, int'(bus.done), 0);
    chk({name, "_preset"}, int'(bus.preset), 0);
    chk({name, "_phase"}, int'(bus.phase), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.preset_in = 4'h0;
    repeat (3) @(negedge clk);
    #2;
    check_reset("por");
    rst = 1'b0;

    // Full run with preset 1111.
    nedge();
    bus.start = 1'b1; bus.preset_in = 4'hF;
    e0 = cyc + 1;
    push_sched(15, e0, 9, t_last);
    nedge();
    bus.start = 1'b0; bus.preset_in = 4'h0;
    wait_drain(60, "full_run");

    // Start pulses while busy, with a different preset, are ignored.
    nedge();
    bus.start = 1'b1; bus.preset_in = 4'hA;
    e0 = cyc + 1;
    push_sched(10, e0, 9, t_last);
    nedge();
    bus.start = 1'b0;
    repeat (3) nedge();
    bus.start = 1'b1; bus.preset_in = 4'h5;
    nedge();
    bus.start = 1'b0;
    while (cyc < e0 + LAT - 2) nedge();
    bus.start = 1'b1;
    nedge();
    bus.start = 1'b0; bus.preset_in = 4'h0;
    wait_drain(60, "start_busy");

    // Abort in the middle of a counter phase.
    nedge();
    bus.start = 1'b1; bus.preset_in = 4'h6;
    e0 = cyc + 1;
    push_sched(6, e0, ABORT_PH, t_last);
    nedge();
    bus.start = 1'b0;
    while (cyc < t_last + 1) nedge();
    bus.abort = 1'b1;
    exp_q.push_back(make_exp(0, t_last + 2, 6));
    nedge();
    bus.abort = 1'b0;
    wait_drain(60, "abort");

    // Start and abort together in IDLE: abort wins.
    nedge();
    bus.start = 1'b1; bus.abort = 1'b1; bus.preset_in = 4'h3;
    nedge();
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (2) nedge();
    chk("start_abort_phase", int'(bus.phase), 0);
    chk("start_abort_busy", int'(bus.busy), 0);
    chk("start_abort_preset", int'(bus.preset), 6);

    // Start held high: second run begins after one IDLE cycle.
    done_cyc.delete();
    nedge();
    bus.start = 1'b1; bus.preset_in = 4'h3;
    e0 = cyc + 1;
    push_sched(3, e0, 9, t_last);
    push_sched(3, e0 + DONE_GAP, 9, t_last);
    while (cyc < e0 + DONE_GAP) nedge();
    bus.start = 1'b0; bus.preset_in = 4'h0;
    wait_drain(80, "held_start");
    chk("held_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("held_done_gap", done_cyc[1] - done_cyc[0], DONE_GAP);

    // Asynchronous reset mid-run.
    nedge();
    bus.start = 1'b1; bus.preset_in = 4'h9;
    e0 = cyc + 1;
    push_sched(9, e0, 9, t_last);
    nedge();
    bus.start = 1'b0;
    while (cyc < e0 + 6) nedge();
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    exp_q.delete();
    nedge();
    rst = 1'b0;
    repeat (2) nedge();
    chk("post_rst_phase", int'(bus.phase), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
